// File: rtl/perceptron_pkg.sv
// Shared constants, FSM state encoding and comm_controller opcodes for the
// perceptron MAC sequencer slice.
package perceptron_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC_W = 8;
  localparam int unsigned Q_ONE      = 1 << DEF_FRAC_W;

  localparam int unsigned ACT_LINEAR = 0;
  localparam int unsigned ACT_STEP   = 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    ISSUE2,
    WAIT,
    ACC,
    DONE
  } state_e;

  typedef enum logic [7:0] {
    OP_READ          = 8'd5,
    OP_WRITE_WEIGHTS = 8'd50,
    OP_WRITE_INPUTS  = 8'd51
  } comm_op_e;

endpackage

// File: rtl/perceptron_pipe_mult.sv
// Signed DATA_W x DATA_W multiplier with MUL_LAT register stages and a valid
// bit travelling alongside the product.
module perceptron_pipe_mult
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0]  a_ext;
  logic [PROD_W-1:0]  b_ext;
  logic [PROD_W-1:0]  prod_d [MUL_LAT];
  logic [PROD_W-1:0]  prod_q [MUL_LAT];
  logic [MUL_LAT-1:0] valid_d;
  logic [MUL_LAT-1:0] valid_q;

  // Sign-extending both operands lets the low PROD_W bits of an unsigned
  // multiply equal the signed product.
  always_comb begin
    a_ext      = {{DATA_W{a[DATA_W-1]}}, a};
    b_ext      = {{DATA_W{b[DATA_W-1]}}, b};
    prod_d[0]  = a_ext * b_ext;
    valid_d    = '0;
    valid_d[0] = in_valid;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      prod_d[i]  = prod_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    prod_q <= prod_d;
  end

  assign out_valid = valid_q[MUL_LAT-1];
  assign product   = prod_q[MUL_LAT-1];

endmodule

// File: rtl/perceptron_mac_sequencer.sv
// Sequences one perceptron evaluation act(w1*x1 + w2*x2) in signed Q8.8 using a
// single time-shared pipelined multiplier, with start/busy/done handshake.
module perceptron_mac_sequencer
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FRAC_W     = DEF_FRAC_W,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned ACT        = ACT_LINEAR,
  parameter int unsigned AUTO_START = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              input_write,
  input  logic [DATA_W-1:0] weight1,
  input  logic [DATA_W-1:0] weight2,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = 2 * DATA_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE_Q = DATA_W'(1) << FRAC_W;

  state_e state_d, state_q;

  logic [DATA_W-1:0]        w1_d, w1_q, x1_d, x1_q;
  logic [DATA_W-1:0]        w2_d, w2_q, x2_d, x2_q;
  logic signed [PROD_W-1:0] p1_d, p1_q, p2_d, p2_q;
  logic                     p1_seen_d, p1_seen_q;
  logic [DATA_W-1:0]        result_d, result_q;
  logic                     overflow_d, overflow_q;

  logic                     go;
  logic                     mul_valid;
  logic [DATA_W-1:0]        mul_a, mul_b;
  logic                     mul_out_valid;
  logic [PROD_W-1:0]        mul_prod;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  shifted;

  perceptron_pipe_mult #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mul_valid),
    .a         (mul_a),
    .b         (mul_b),
    .out_valid (mul_out_valid),
    .product   (mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    w1_d       = w1_q;
    x1_d       = x1_q;
    w2_d       = w2_q;
    x2_d       = x2_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    p1_seen_d  = p1_seen_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    mul_valid  = 1'b0;
    mul_a      = w1_q;
    mul_b      = x1_q;

    go      = start | ((AUTO_START != 0) & input_write);
    sum     = SUM_W'(p1_q) + SUM_W'(p2_q);
    shifted = sum >>> FRAC_W;

    // The first valid product out of the pipe is always w1*x1; with MUL_LAT=1
    // it emerges while still in ISSUE2, so capture is not tied to WAIT.
    if (state_q != IDLE && mul_out_valid && !p1_seen_q) begin
      p1_d      = signed'(mul_prod);
      p1_seen_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          w1_d      = weight1;
          x1_d      = data_in1;
          w2_d      = weight2;
          x2_d      = data_in2;
          p1_seen_d = 1'b0;
          state_d   = ISSUE1;
        end
      end
      ISSUE1: begin
        mul_valid = 1'b1;
        state_d   = ISSUE2;
      end
      ISSUE2: begin
        mul_valid = 1'b1;
        mul_a     = w2_q;
        mul_b     = x2_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mul_out_valid && p1_seen_q) begin
          p2_d    = signed'(mul_prod);
          state_d = ACC;
        end
      end
      ACC: begin
        if (ACT == ACT_STEP) begin
          result_d   = (sum >= 0) ? ONE_Q : '0;
          overflow_d = 1'b0;
        end else if (shifted > SAT_MAX) begin
          result_d   = SAT_MAX[DATA_W-1:0];
          overflow_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
          result_d   = SAT_MIN[DATA_W-1:0];
          overflow_d = 1'b1;
        end else begin
          result_d   = shifted[DATA_W-1:0];
          overflow_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      p1_seen_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_seen_q  <= p1_seen_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      w1_q       <= w1_d;
      x1_q       <= x1_d;
      w2_q       <= w2_d;
      x2_q       <= x2_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_perceptron_mac_sequencer.sv
// Directed bench for perceptron_mac_sequencer across linear/step, auto-start
// and several multiplier latencies.
module tb_perceptron_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic        input_write;
  logic [15:0] w1, x1, w2, x2;
  logic [3:0]  busy_v, done_v, ovf_v;
  logic [15:0] res_v [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: default linear, MUL_LAT=2
  perceptron_mac_sequencer #(
    .DATA_W(16), .FRAC_W(8), .MUL_LAT(2), .ACT(0), .AUTO_START(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .input_write(input_write),
    .weight1(w1), .weight2(w2), .data_in1(x1), .data_in2(x2),
    .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .overflow(ovf_v[0])
  );

  // 1: step activation
  perceptron_mac_sequencer #(
    .DATA_W(16), .FRAC_W(8), .MUL_LAT(2), .ACT(1), .AUTO_START(0)
  ) dut_step (
    .clk(clk), .rst(rst), .start(start_v[1]), .input_write(input_write),
    .weight1(w1), .weight2(w2), .data_in1(x1), .data_in2(x2),
    .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .overflow(ovf_v[1])
  );

  // 2: auto-start, MUL_LAT=1
  perceptron_mac_sequencer #(
    .DATA_W(16), .FRAC_W(8), .MUL_LAT(1), .ACT(0), .AUTO_START(1)
  ) dut_auto (
    .clk(clk), .rst(rst), .start(start_v[2]), .input_write(input_write),
    .weight1(w1), .weight2(w2), .data_in1(x1), .data_in2(x2),
    .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .overflow(ovf_v[2])
  );

  // 3: MUL_LAT=4
  perceptron_mac_sequencer #(
    .DATA_W(16), .FRAC_W(8), .MUL_LAT(4), .ACT(0), .AUTO_START(0)
  ) dut_l4 (
    .clk(clk), .rst(rst), .start(start_v[3]), .input_write(input_write),
    .weight1(w1), .weight2(w2), .data_in1(x1), .data_in2(x2),
    .busy(busy_v[3]), .done(done_v[3]), .result(res_v[3]), .overflow(ovf_v[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One evaluation on DUT idx; lat is the number of edges after the
  // accepting edge T0 at which done is first seen high.
  task automatic run(input int idx, input int lat, input logic use_iw,
                     input logic [15:0] a1, input logic [15:0] b1,
                     input logic [15:0] a2, input logic [15:0] b2,
                     input logic [15:0] exp_r, input logic exp_o,
                     input string tag);
    int cyc;
    @(negedge clk);
    w1 = a1; x1 = b1; w2 = a2; x2 = b2;
    if (use_iw) input_write = 1'b1;
    else        start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v     = '0;
    input_write = 1'b0;
    check({tag, "_busy"}, 32'(busy_v[idx]), 32'd1);
    if (use_iw) check({tag, "_iw_ignored"}, 32'(busy_v[0]), 32'd0);
    cyc = 0;
    while (!done_v[idx] && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_res"}, 32'(res_v[idx]), 32'(exp_r));
    check({tag, "_ovf"}, 32'(ovf_v[idx]), 32'(exp_o));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done_v[idx]), 32'd0);
    check({tag, "_idle"}, 32'(busy_v[idx]), 32'd0);
    check({tag, "_hold"}, 32'(res_v[idx]), 32'(exp_r));
  endtask

  initial begin
    int          dones;
    logic [15:0] seen_r;
    logic        seen_o;

    rst = 1'b1; start_v = '0; input_write = 1'b0;
    w1 = '0; x1 = '0; w2 = '0; x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_done", 32'(done_v[i]), 32'd0);
      check("rst_res",  32'(res_v[i]),  32'd0);
      check("rst_ovf",  32'(ovf_v[i]),  32'd0);
    end

    // Basic, saturation, floor
    run(0, 5, 1'b0, 16'h0100, 16'h0300, 16'h0200, 16'h0080, 16'h0400, 1'b0, "basic");
    run(0, 5, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "sat_pos");
    run(0, 5, 1'b0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, "sat_neg");
    run(0, 5, 1'b0, 16'hFF00, 16'h0180, 16'h0000, 16'h0000, 16'hFE80, 1'b0, "neg");
    run(0, 5, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, "floor");

    // Step activation
    run(1, 5, 1'b0, 16'hFF00, 16'h0180, 16'h0000, 16'h0000, 16'h0000, 1'b0, "step_neg");
    run(1, 5, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, "step_pos");

    // Auto-start with MUL_LAT=1, and MUL_LAT=4
    run(2, 4, 1'b1, 16'h0100, 16'h0300, 16'h0200, 16'h0080, 16'h0400, 1'b0, "auto_l1");
    run(3, 7, 1'b0, 16'h0100, 16'h0300, 16'h0200, 16'h0080, 16'h0400, 1'b0, "lat4");

    // Start held 3 cycles, operands disturbed while busy
    @(negedge clk);
    w1 = 16'h0200; x1 = 16'h0200; w2 = 16'h0100; x2 = 16'hFF00;
    start_v[0] = 1'b1;
    dones = 0; seen_r = '0; seen_o = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        w1 = 16'h7FFF; x1 = 16'h7FFF; w2 = 16'h7FFF; x2 = 16'h7FFF;
      end
      if (i == 2) start_v[0] = 1'b0;
      if (done_v[0]) begin
        dones++;
        seen_r = res_v[0];
        seen_o = ovf_v[0];
      end
      if (i == 10) check("held_busy_after", 32'(busy_v[0]), 32'd0);
    end
    check("held_dones", 32'(dones), 32'd1);
    check("held_res", 32'(seen_r), 32'h0300);
    check("held_ovf", 32'(seen_o), 32'd0);

    // Reset while in WAIT
    @(negedge clk);
    w1 = 16'h0100; x1 = 16'h0300; w2 = 16'h0200; x2 = 16'h0080;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_busy", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_res", 32'(res_v[0]), 32'd0);
    check("abort_ovf", 32'(ovf_v[0]), 32'd0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) dones++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run(0, 5, 1'b0, 16'h0100, 16'h0300, 16'h0200, 16'h0080, 16'h0400, 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
